// File: rtl/lsu_pkg.sv
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared funct3 codes, FSM and access-size types for the LSU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // funct3[1:0] carries the access size; funct3[2] only selects zero-extension.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_ctrl_if.sv
// ============================================================================
// Module  : lsu_ctrl_if
// Brief   : Pipeline request/response and DMEM port bundle for lsu_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_ctrl_if #(
  parameter int XLEN = 32
);

  logic            req_valid;
  logic            req_ready;
  logic            req_load;
  logic            req_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_misalign;
  logic            rsp_fault;
  logic            rsp_illegal;

  logic            dmem_MemRead;
  logic            dmem_MemWrite;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_WriteData;
  logic [XLEN-1:0] dmem_ReadData;

  // Environment side: pipeline requester plus the DMEM read port.
  modport master (
    output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
    output dmem_ReadData,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_misalign, rsp_fault, rsp_illegal,
    input  dmem_MemRead, dmem_MemWrite, dmem_addr, dmem_WriteData
  );

  // LSU side.
  modport slave (
    input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
    input  dmem_ReadData,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_misalign, rsp_fault, rsp_illegal,
    output dmem_MemRead, dmem_MemWrite, dmem_addr, dmem_WriteData
  );

endinterface

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
// Module  : lsu_lane_align
// Brief   : Combinational byte/halfword lane extract+extend and store merge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic [XLEN-1:0] rword_i,
  input  wire logic [1:0]      off_i,
  input  wire lsu_size_t       size_i,
  input  wire logic            unsigned_i,
  input  wire logic [XLEN-1:0] wdata_i,
  output logic      [XLEN-1:0] load_o,
  output logic      [XLEN-1:0] merge_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_bsel;
  logic [4:0]  w_hsel;

  assign w_bsel = {off_i, 3'b000};
  assign w_hsel = {off_i[1], 4'b0000};

  always_comb begin
    w_byte = rword_i[w_bsel +: 8];
    w_half = rword_i[w_hsel +: 16];
    load_o = rword_i;
    case (size_i)
      SZ_B:    load_o = {{(XLEN-8){w_byte[7] & ~unsigned_i}}, w_byte};
      SZ_H:    load_o = {{(XLEN-16){w_half[15] & ~unsigned_i}}, w_half};
      default: load_o = rword_i;
    endcase
  end

  // Halfword lane is picked by off_i[1] alone; alignment is guaranteed upstream.
  always_comb begin
    merge_o = rword_i;
    case (size_i)
      SZ_B:    merge_o[w_bsel +: 8]  = wdata_i[7:0];
      SZ_H:    merge_o[w_hsel +: 16] = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module  : lsu_ctrl
// Brief   : Load/store unit: classify, access word-only DMEM, RMW for SB/SH.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              DMEM_WORDS = 256,
  parameter logic [XLEN-1:0] DMEM_BASE  = '0
) (
  input wire logic  clk,
  input wire logic  rst,
  lsu_ctrl_if.slave bus
);

  localparam logic [XLEN-1:0] c_words = XLEN'(DMEM_WORDS);

  lsu_state_t      state_q, state_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            mis_q, mis_d;
  logic            fault_q, fault_d;
  logic            ill_q, ill_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      off_q, off_d;
  lsu_size_t       size_q, size_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] word_q, word_d;

  lsu_size_t       w_size;
  logic            w_ld_f3_ok;
  logic            w_st_f3_ok;
  logic            w_illegal;
  logic            w_misalign;
  logic            w_fault;
  logic [XLEN-1:0] w_rel;
  logic [XLEN-1:0] w_waddr;
  logic            w_accept;

  logic            w_req_ready;
  logic            w_mem_read;
  logic            w_mem_write;
  logic [XLEN-1:0] w_mem_addr;
  logic [XLEN-1:0] w_mem_wdata;

  logic [XLEN-1:0] w_la_word;
  logic [1:0]      w_la_off;
  lsu_size_t       w_la_size;
  logic            w_la_unsigned;
  logic [XLEN-1:0] w_la_wdata;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_merge;

  // Request classification.
  assign w_size     = f3_size(bus.req_funct3);
  assign w_ld_f3_ok = bus.req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  assign w_st_f3_ok = bus.req_funct3 inside {F3_B, F3_H, F3_W};
  assign w_illegal  = (bus.req_load == bus.req_store)
                    | (bus.req_load  & ~w_ld_f3_ok)
                    | (bus.req_store & ~w_st_f3_ok);
  assign w_misalign = ((w_size == SZ_H) & bus.req_addr[0])
                    | ((w_size == SZ_W) & (bus.req_addr[1:0] != 2'b00));
  // Unsigned wrap makes addresses below DMEM_BASE land far above the window.
  assign w_rel      = bus.req_addr - DMEM_BASE;
  assign w_fault    = (w_rel >> 2) >= c_words;
  assign w_waddr    = {bus.req_addr[XLEN-1:2], 2'b00};
  assign w_accept   = (state_q == IDLE) & bus.req_valid & ~rst;

  // One aligner serves the live load path in IDLE and the latched merge in MERGE.
  assign w_la_word     = (state_q == MERGE) ? word_q  : bus.dmem_ReadData;
  assign w_la_off      = (state_q == MERGE) ? off_q   : bus.req_addr[1:0];
  assign w_la_size     = (state_q == MERGE) ? size_q  : w_size;
  assign w_la_unsigned = bus.req_funct3[2];
  assign w_la_wdata    = (state_q == MERGE) ? wdata_q : bus.req_wdata;

  lsu_lane_align #(
    .XLEN (XLEN)
  ) u_lane_align (
    .rword_i    (w_la_word),
    .off_i      (w_la_off),
    .size_i     (w_la_size),
    .unsigned_i (w_la_unsigned),
    .wdata_i    (w_la_wdata),
    .load_o     (w_load),
    .merge_o    (w_merge)
  );

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    mis_d       = 1'b0;
    fault_d     = 1'b0;
    ill_d       = 1'b0;
    addr_d      = addr_q;
    off_d       = off_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    w_req_ready = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;

    case (state_q)
      IDLE: begin
        w_req_ready = 1'b1;
        if (w_accept) begin
          rsp_valid_d = 1'b1;
          if (w_illegal) begin
            ill_d = 1'b1;
          end else if (w_misalign) begin
            mis_d = 1'b1;
          end else if (w_fault) begin
            fault_d = 1'b1;
          end else if (bus.req_load) begin
            w_mem_read  = 1'b1;
            w_mem_addr  = w_waddr;
            rsp_rdata_d = w_load;
          end else if (w_size == SZ_W) begin
            w_mem_write = 1'b1;
            w_mem_addr  = w_waddr;
            w_mem_wdata = bus.req_wdata;
          end else begin
            // Sub-word store: read the word now, write the merged word next cycle.
            w_mem_read  = 1'b1;
            w_mem_addr  = w_waddr;
            rsp_valid_d = 1'b0;
            addr_d      = w_waddr;
            off_d       = bus.req_addr[1:0];
            size_d      = w_size;
            wdata_d     = bus.req_wdata;
            word_d      = bus.dmem_ReadData;
            state_d     = MERGE;
          end
        end
      end

      MERGE: begin
        if (!rst) begin
          w_mem_write = 1'b1;
          w_mem_addr  = addr_q;
          w_mem_wdata = w_merge;
          rsp_valid_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      mis_q       <= 1'b0;
      fault_q     <= 1'b0;
      ill_q       <= 1'b0;
      addr_q      <= '0;
      off_q       <= 2'b00;
      size_q      <= SZ_B;
      wdata_q     <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mis_q       <= mis_d;
      fault_q     <= fault_d;
      ill_q       <= ill_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      word_q      <= word_d;
    end
  end

  assign bus.req_ready      = w_req_ready;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_misalign   = mis_q;
  assign bus.rsp_fault      = fault_q;
  assign bus.rsp_illegal    = ill_q;
  assign bus.dmem_MemRead   = w_mem_read;
  assign bus.dmem_MemWrite  = w_mem_write;
  assign bus.dmem_addr      = w_mem_addr;
  assign bus.dmem_WriteData = w_mem_wdata;

endmodule

`default_nettype wire
